// File: rtl/f1_random_delay_if.sv
// F1 random delay stage handshake bundle.
// The sequencer drives trigger; the delay stage drives the rest.
interface f1_random_delay_if;
    logic       trigger;
    logic       time_out;
    logic       busy;
    logic [6:0] delay_units;
    logic [6:0] lfsr_q;

    modport master (
        output trigger,
        input  time_out,
        input  busy,
        input  delay_units,
        input  lfsr_q
    );

    modport slave (
        input  trigger,
        output time_out,
        output busy,
        output delay_units,
        output lfsr_q
    );
endinterface

// File: rtl/f1_random_delay.sv
// F1 start-light lights-out random delay stage.
// Waits K prescaled units after a trigger rise, then pulses time_out.
module f1_random_delay #(
    parameter int TICK_DIV  = 1000,
    parameter int MIN_UNITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    f1_random_delay_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE    = PW'(1);
    localparam logic [6:0]    MIN_K      = 7'(MIN_UNITS);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE,
        WAIT_LOW
    } state_t;

    state_t        state;
    logic          trigger_q;
    logic [PW-1:0] prescaler;
    logic [6:0]    units;
    logic [6:0]    lfsr;
    logic [6:0]    delay_r;
    logic          time_out_r;
    logic          busy_r;

    logic          rise;
    logic [6:0]    k_cap;

    assign rise  = bus.trigger & ~trigger_q;
    assign k_cap = (lfsr < MIN_K) ? MIN_K : lfsr;

    assign bus.time_out    = time_out_r;
    assign bus.busy        = busy_r;
    assign bus.delay_units = delay_r;
    assign bus.lfsr_q      = lfsr;

    // Free-running x^7+x^6+1 LFSR; recovers from the all-zero lockup state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h01;
        end else if (lfsr == 7'h00) begin
            lfsr <= 7'h01;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    // Previous trigger level for rise detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= bus.trigger;
        end
    end

    // Delay sequencer: capture K, count K units, pulse, wait for release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prescaler  <= '0;
            units      <= 7'd0;
            delay_r    <= 7'd0;
            time_out_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            time_out_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy_r <= 1'b0;
                    if (rise) begin
                        delay_r   <= k_cap;
                        units     <= k_cap;
                        prescaler <= PRE_RELOAD;
                        busy_r    <= 1'b1;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    if (!bus.trigger) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (prescaler == '0) begin
                        prescaler <= PRE_RELOAD;
                        units     <= units - 7'd1;
                        if (units == 7'd1) begin
                            time_out_r <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        prescaler <= prescaler - PRE_ONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    busy_r <= 1'b0;
                    if (!bus.trigger) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_random_delay.sv
// Bench for f1_random_delay: directed steps plus random trigger
// patterns against a deadline-based reference model.
module tb_f1_random_delay;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    f1_random_delay_if ifa ();
    f1_random_delay_if ifb ();

    f1_random_delay #(.TICK_DIV(TD), .MIN_UNITS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    f1_random_delay #(.TICK_DIV(TD), .MIN_UNITS(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] seq [127];

    // reference model: edge index since reset, in-flight deadline
    int         n;
    bit         m_active;
    bit         m_wait;
    bit         m_prev;
    int         m_deadline;
    int         m_cap;
    logic [6:0] m_k;
    bit         exp_to;
    bit         exp_busy;

    function automatic logic [6:0] lf_at(input int i);
        return seq[7'(i % 127)];
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t);
        logic [6:0] lf;
        @(negedge clk);
        ifa.trigger = t;
        @(posedge clk);
        n++;
        lf = lf_at(n - 1);
        exp_to = 1'b0;
        if (m_active) begin
            if (!t) begin
                m_active = 1'b0;
            end else if (n == m_deadline) begin
                m_active = 1'b0;
                m_wait   = 1'b1;
                exp_to   = 1'b1;
            end
        end else if (m_wait) begin
            if (n >= m_deadline + 2 && !t) m_wait = 1'b0;
        end else if (t && !m_prev) begin
            m_k        = (lf > 7'd1) ? lf : 7'd1;
            m_cap      = n;
            m_deadline = n + int'(m_k) * TD;
            m_active   = 1'b1;
        end
        m_prev   = t;
        exp_busy = m_active || exp_to;
        #1;
        check("time_out", 32'(ifa.time_out), 32'(exp_to));
        check("busy", 32'(ifa.busy), 32'(exp_busy));
        check("delay_units", 32'(ifa.delay_units), 32'(m_k));
        check("lfsr_q", 32'(ifa.lfsr_q), 32'(lf_at(n)));
    endtask

    task automatic apply_reset(input logic trig_a);
        @(negedge clk);
        #2;
        rst = 1'b1;
        ifa.trigger = trig_a;
        ifb.trigger = 1'b0;
        #1;
        check("rst_a_time_out", 32'(ifa.time_out), 32'd0);
        check("rst_a_busy", 32'(ifa.busy), 32'd0);
        check("rst_a_units", 32'(ifa.delay_units), 32'd0);
        check("rst_a_lfsr", 32'(ifa.lfsr_q), 32'h01);
        check("rst_b_time_out", 32'(ifb.time_out), 32'd0);
        check("rst_b_busy", 32'(ifb.busy), 32'd0);
        check("rst_b_units", 32'(ifb.delay_units), 32'd0);
        check("rst_b_lfsr", 32'(ifb.lfsr_q), 32'h01);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        n        = 0;
        m_active = 1'b0;
        m_wait   = 1'b0;
        m_prev   = 1'b0;
        m_k      = 7'd0;
    endtask

    task automatic run_until_pulse(input int cap, output int lat);
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            step(1'b1);
            if (ifa.time_out === 1'b1) begin
                lat = n - cap;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] early [8];
        int pulses;
        int pe;
        int cap;
        int lat;

        early[0] = 7'h01; early[1] = 7'h02;
        early[2] = 7'h04; early[3] = 7'h08;
        early[4] = 7'h10; early[5] = 7'h20;
        early[6] = 7'h41; early[7] = 7'h03;

        seq[0] = 7'h01;
        for (int i = 1; i < 127; i++) begin
            seq[7'(i)] = {seq[7'(i - 1)][5:0],
                          seq[7'(i - 1)][6] ^ seq[7'(i - 1)][5]};
        end

        rst = 1'b0;
        ifa.trigger = 1'b0;
        ifb.trigger = 1'b0;
        repeat (2) @(posedge clk);

        // 1: asynchronous reset mid-cycle
        apply_reset(1'b0);

        // 2: LFSR free-run and period
        for (int i = 0; i < 127; i++) begin
            step(1'b0);
            check("lfsr_nonzero", 32'(ifa.lfsr_q != 7'h00), 32'd1);
            if (i < 7) begin
                check("lfsr_early", 32'(ifa.lfsr_q), 32'(early[i + 1]));
            end
            if (i < 126) begin
                check("lfsr_no_early_wrap", 32'(ifa.lfsr_q == 7'h01), 32'd0);
            end
        end
        check("lfsr_period", 32'(ifa.lfsr_q), 32'h01);

        // 3: capture at lfsr_q = 08, 32-edge delay
        for (int g = 0; g < 130 && lf_at(n) != 7'h08; g++) step(1'b0);
        step(1'b1);
        cap = n;
        check("t3_units", 32'(ifa.delay_units), 32'd8);
        check("t3_busy", 32'(ifa.busy), 32'd1);
        pulses = 0;
        pe = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (ifa.time_out === 1'b1) begin
                pulses++;
                if (pe == 0) pe = n;
            end
        end
        check("t3_pulse_count", 32'(pulses), 32'd1);
        check("t3_latency", 32'(pe - cap), 32'd32);

        // 4: abort five cycles after raise
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (4) step(1'b1);
        step(1'b0);
        check("t4_abort_busy", 32'(ifa.busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (ifa.time_out === 1'b1) pulses++;
        end
        check("t4_no_pulse", 32'(pulses), 32'd0);
        step(1'b1);
        cap = n;
        run_until_pulse(cap, lat);
        check("t4_latency", 32'(lat), 32'(int'(m_k) * TD));

        // 5: hold high after pulse, then retrigger
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1);
            if (ifa.time_out === 1'b1) pulses++;
        end
        check("t5_single_pulse", 32'(pulses), 32'd0);
        repeat (2) step(1'b0);
        step(1'b1);
        cap = n;
        run_until_pulse(cap, lat);
        check("t5_latency", 32'(lat), 32'(int'(m_k) * TD));

        // random trigger patterns
        for (int t = 0; t < 15; t++) begin
            repeat ($urandom_range(0, 130)) step(1'b0);
            repeat ($urandom_range(1, 560)) step(1'b1);
            repeat ($urandom_range(1, 4)) step(1'b0);
        end

        // 6: clamp on second instance, then reset during COUNT
        apply_reset(1'b0);
        repeat (7) step(1'b0);
        ifb.trigger = 1'b1;
        step(1'b0);
        check("t6_clamp_units", 32'(ifb.delay_units), 32'd16);
        check("t6_busy", 32'(ifb.busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("t6_count_busy", 32'(ifb.busy), 32'd1);
            check("t6_count_to", 32'(ifb.time_out), 32'd0);
        end
        apply_reset(1'b1);
        for (int i = 0; i < 100; i++) begin
            step(1'b1);
            check("t6_post_to", 32'(ifb.time_out), 32'd0);
            check("t6_post_busy", 32'(ifb.busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
